serial_pe: RTL and testbench
============================

// Module: serial_pe
// PURPOSE
//  Serial multiply-accumulate processing element: one 16-bit neuron x 16-bit weight per cycle.
//  Accumulates a dot product of arbitrary length framed by ctl[0] (first) and ctl[1] (last).
//  Emits one 32-bit result per dot product with a single-cycle valid pulse.
//  Sits behind a sequencer that streams operands from neuron/weight buffers (32 lanes per line).
// PARAMETERS
//  DW    16  operand width (neuron, weight), signed two's complement
//  RW    32  result / accumulator width
// PORTS
//  clk     in   1   clock, all state updates on rising edge
//  rst_n   in   1   reset, asynchronous, active-low
//  neuron  in   16  signed neuron operand
//  weight  in   16  signed weight operand
//  ctl     in   2   [0]=first element of dot product, [1]=last element; sampled only when vld_i=1
//  vld_i   in   1   operand/ctl valid this cycle
//  result  out  32  completed dot product (signed, modulo 2^32)
//  vld_o   out  1   one-cycle pulse: result valid
// BEHAVIOUR
//  - Reset (async, rst_n=0): product reg, accumulator, result, vld_o and all pipeline valids cleared to 0.
//  - vld_i=0: no state change in the MAC path; ctl ignored; pipeline bubbles advance (valid=0).
//  - Stage 1 (cycle T, vld_i=1): register p = $signed(neuron)*$signed(weight) (full 32-bit product),
//    together with the first/last flags and a valid bit.
//  - Stage 2 (T+1, stage-1 valid): acc <= first ? p : acc + p; sum truncated to 32 bits (wraps).
//  - Output (T+2): if stage-2 element was last, result <= final acc value, vld_o <= 1 for one cycle;
//    otherwise vld_o <= 0 and result holds its previous value.
//  - Latency: vld_o rises exactly 2 cycles after the clock edge sampling vld_i=1 & ctl[1]=1.
//  - first and last in the same element: result = that single product.
//  - First element without prior last: previous partial sum is discarded (restart).
//  - Last element of one vector directly followed (next cycle) by first of the next: no bubble
//    needed; back-to-back results, each with its own vld_o pulse.
//  - Gaps (vld_i=0) inside a vector are allowed; accumulation resumes on next valid element.
//  - Elements arriving with neither flag before any first: accumulate onto current acc (0 after reset).
//  - Overflow: no saturation; two's-complement wrap at 32 bits on both product and sum.
//  - Reset mid-vector: partial sum lost, no vld_o issued for the aborted vector.
//  - result is stable between vld_o pulses; vld_o never asserted for two consecutive cycles
//    unless two last elements arrive on consecutive valid cycles.
// TESTING
//  1. Reset: hold rst_n=0 -> result=0, vld_o=0; release, idle -> vld_o stays 0.
//  2. 32-element vector, all neuron=1, weight=2, ctl[0] on elem 0, ctl[1] on elem 31
//     -> vld_o pulse 2 cycles after elem 31, result=64.
//  3. Signed: single element neuron=16'hFFFF(-1), weight=16'h0003, ctl=2'b11 -> result=32'hFFFFFFFD.
//  4. Back-to-back vectors: {3x4 , 5x6} then immediately {-2x7} with one-cycle vld_i gap
//     -> results 42 then 32'hFFFFFFF2, two separate vld_o pulses.
//  5. Wrap: 4 elements of 16'h7FFF x 16'h7FFF -> result = (4*32'h3FFF0001) mod 2^32 = 32'hFFFC0004.
//  6. Four consecutive 64-, 96-, 32-, 128-element vectors with random operands vs software model
//     (low 32 bits of signed dot product) -> four vld_o pulses, all results match.

Source files
------------

// File: rtl/serial_pe.sv
// Serial multiply-accumulate PE: one signed DW x DW product per valid cycle, accumulated
// into a RW-bit dot product framed by first/last flags, result emitted with a one-cycle pulse.
module serial_pe #(
  parameter int DW = 16,
  parameter int RW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] neuron,
  input  logic [DW-1:0] weight,
  input  logic [1:0]    ctl,
  input  logic          vld_i,
  output logic [RW-1:0] result,
  output logic          vld_o
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic          first;
    logic          last;
    logic [RW-1:0] p;
  } s1_t;

  s1_t                    s1_q;
  logic [STAGES:1]        vld_pipe;
  logic [RW-1:0]          acc_q;
  logic                   last2_q;
  logic signed [2*DW-1:0] prod_full;
  logic signed [RW-1:0]   prod_rw;

  assign prod_full = $signed(neuron) * $signed(weight);
  assign prod_rw   = RW'(prod_full);

  // Stage 1: register product and framing flags; operands/ctl are ignored on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      vld_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_i;
      if (vld_i) begin
        s1_q.first <= ctl[0];
        s1_q.last  <= ctl[1];
        s1_q.p     <= prod_rw;
      end
    end
  end

  // Stage 2: a first element restarts the sum, discarding any unfinished vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      last2_q     <= 1'b0;
      vld_pipe[2] <= 1'b0;
    end else begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        acc_q   <= s1_q.first ? s1_q.p : acc_q + s1_q.p;
        last2_q <= s1_q.last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      vld_o  <= 1'b0;
    end else begin
      vld_o <= vld_pipe[2] & last2_q;
      if (vld_pipe[2] && last2_q) result <= acc_q;
    end
  end

endmodule

// File: tb/tb_serial_pe.sv
// Directed bench for serial_pe: framing, latency, signed/wrap arithmetic, resets, random vectors.
module tb_serial_pe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] neuron, weight;
  logic [1:0]  ctl;
  logic        vld_i;
  logic [31:0] result;
  logic        vld_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [31:0] q_res[$];
  int          q_cyc[$];

  serial_pe #(.DW(16), .RW(32)) dut (
    .clk(clk), .rst_n(rst_n), .neuron(neuron), .weight(weight),
    .ctl(ctl), .vld_i(vld_i), .result(result), .vld_o(vld_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (vld_o) begin q_res.push_back(result); q_cyc.push_back(cyc); end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Idle cycles carry garbage operands and ctl=11 so that ctl is shown to be ignored.
  task automatic send(input logic [15:0] n, input logic [15:0] w, input logic [1:0] c);
    neuron = n; weight = w; ctl = c; vld_i = 1'b1;
    @(posedge clk); #1;
    vld_i = 1'b0; ctl = 2'b11; neuron = 16'h5A5A; weight = 16'hA5A5;
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int l1, l2;
    int lens[4];
    int expv[4];
    int lastc[4];
    logic [15:0] n, w;
    int pr;

    rst_n = 1'b0; vld_i = 1'b0; ctl = 2'b11; neuron = 16'h1234; weight = 16'h4321;
    idle(3);
    check("reset_result", result, 32'h0);
    check("reset_vld", {31'b0, vld_o}, 32'h0);
    rst_n = 1'b1;
    idle(5);
    check("idle_no_pulse", q_res.size(), 0);

    // 32-element all 1x2 vector
    q_res.delete(); q_cyc.delete();
    for (int i = 0; i < 32; i++) send(16'd1, 16'd2, {i == 31, i == 0});
    l1 = cyc;
    idle(4);
    check("vec32_count", q_res.size(), 1);
    check("vec32_result", q_res[0], 32'd64);
    check("vec32_latency", q_cyc[0], l1 + 2);
    check("vec32_hold", result, 32'd64);

    // single signed element
    q_res.delete(); q_cyc.delete();
    send(16'hFFFF, 16'h0003, 2'b11);
    idle(4);
    check("signed_count", q_res.size(), 1);
    check("signed_result", q_res[0], 32'hFFFFFFFD);

    // two vectors separated by a one-cycle gap
    q_res.delete(); q_cyc.delete();
    send(16'd3, 16'd4, 2'b01);
    send(16'd5, 16'd6, 2'b10);
    l1 = cyc;
    idle(1);
    send(16'hFFFE, 16'd7, 2'b11);
    l2 = cyc;
    idle(4);
    check("b2b_count", q_res.size(), 2);
    check("b2b_res0", q_res[0], 32'd42);
    check("b2b_res1", q_res[1], 32'hFFFFFFF2);
    check("b2b_cyc0", q_cyc[0], l1 + 2);
    check("b2b_cyc1", q_cyc[1], l2 + 2);

    // two last elements on consecutive cycles
    q_res.delete(); q_cyc.delete();
    send(16'd2, 16'd3, 2'b11);
    send(16'd4, 16'd5, 2'b11);
    l1 = cyc;
    idle(4);
    check("consec_count", q_res.size(), 2);
    check("consec_res0", q_res[0], 32'd6);
    check("consec_res1", q_res[1], 32'd20);
    check("consec_cyc1", q_cyc[1], l1 + 2);

    // wrap at 32 bits
    q_res.delete(); q_cyc.delete();
    for (int i = 0; i < 4; i++) send(16'h7FFF, 16'h7FFF, {i == 3, i == 0});
    idle(4);
    check("wrap_count", q_res.size(), 1);
    check("wrap_result", q_res[0], 32'hFFFC0004);

    // asynchronous reset clears result without a clock edge
    #2 rst_n = 1'b0;
    #1 check("async_reset", result, 32'h0);
    idle(1);
    rst_n = 1'b1;
    idle(2);

    // a second first element restarts the sum
    q_res.delete(); q_cyc.delete();
    send(16'd10, 16'd10, 2'b01);
    send(16'd2, 16'd3, 2'b01);
    send(16'd1, 16'd1, 2'b10);
    idle(4);
    check("restart_result", q_res[0], 32'd7);

    // reset mid-vector: no pulse, accumulator restarts from 0
    q_res.delete(); q_cyc.delete();
    send(16'd5, 16'd5, 2'b01);
    send(16'd7, 16'd7, 2'b00);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    check("abort_no_pulse", q_res.size(), 0);
    send(16'd1, 16'd1, 2'b10);
    idle(4);
    check("after_reset_acc", q_res[0], 32'd1);

    // elements without first keep accumulating onto acc (1 + 9 + 4)
    q_res.delete(); q_cyc.delete();
    send(16'd3, 16'd3, 2'b00);
    idle(2);
    send(16'd2, 16'd2, 2'b10);
    idle(4);
    check("noflag_accum", q_res[0], 32'd14);

    // four random vectors with random gaps
    q_res.delete(); q_cyc.delete();
    lens = '{64, 96, 32, 128};
    for (int v = 0; v < 4; v++) begin
      expv[v] = 0;
      for (int i = 0; i < lens[v]; i++) begin
        n = 16'($urandom);
        w = 16'($urandom);
        pr = $signed(n) * $signed(w);
        expv[v] = expv[v] + pr;
        if ($urandom_range(0, 5) == 0) idle(1);
        send(n, w, {i == lens[v] - 1, i == 0});
      end
      lastc[v] = cyc;
    end
    idle(4);
    check("rand_count", q_res.size(), 4);
    for (int v = 0; v < 4; v++) begin
      if (v < q_res.size()) begin
        check($sformatf("rand_res%0d", v), q_res[v], expv[v]);
        check($sformatf("rand_cyc%0d", v), q_cyc[v], lastc[v] + 2);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
